// File: rtl/generic_sram_pkg.sv
// Shared constants for the generic dual-port SRAM model: port priority and read mode.
package generic_sram_pkg;

    typedef enum logic {
        READ_FIRST = 1'b0
    } read_mode_e;

    // Port 0 data is stored when both ports write the same address in one cycle.
    localparam bit PORT0_WINS = 1'b1;
    localparam read_mode_e READ_MODE = READ_FIRST;

    typedef enum logic {
        INIT = 1'b0,
        DONE = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/sram_init_sweeper.sv
// Zero-initialisation sweep: walks every address once after reset, then raises init_done.
module sram_init_sweeper
    import generic_sram_pkg::*;
#(
    parameter int abits = 12
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [abits-1:0] sweep_addr,
    output logic             sweep_we,
    output logic             init_done
);

    sweep_state_e     state, state_nxt;
    logic [abits-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                // The edge that writes the last address also flips to DONE.
                if (cnt == {abits{1'b1}})
                    state_nxt = DONE;
            end
            DONE: ;
            default: state_nxt = INIT;
        endcase
    end

    assign sweep_addr = cnt;
    assign init_done  = (state == DONE);

endmodule

// File: rtl/generic_dual_port_sram.sv
// True dual-port read-first SRAM, 2^abits x dbits, with reset-time zero sweep.
// Optional GENERIC_SRAM_COLLISION_FLAG_EN adds a registered same-address collision flag.
module generic_dual_port_sram
    import generic_sram_pkg::*;
#(
    parameter int abits = 12,
    parameter int dbits = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [abits-1:0] a0,
    input  logic [dbits-1:0] d0,
    input  logic             we0,
    output logic [dbits-1:0] q0,
    input  logic [abits-1:0] a1,
    input  logic [dbits-1:0] d1,
    input  logic             we1,
    output logic [dbits-1:0] q1,
`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
    output logic             collision,
`endif
    output logic             init_done
);

    localparam int DEPTH = 1 << abits;

    logic [dbits-1:0] mem [DEPTH];
    logic [abits-1:0] sweep_addr;
    logic             sweep_we;

    sram_init_sweeper #(.abits(abits)) u_sweeper (
        .clk        (clk),
        .rstn       (rstn),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we),
        .init_done  (init_done)
    );

    // Unknown addresses never reach the array; synthesis folds these to 1.
    logic a0_ok, a1_ok;
    assign a0_ok = ((^a0) !== 1'bx);
    assign a1_ok = ((^a1) !== 1'bx);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q0 <= '0;
            q1 <= '0;
        end else if (!init_done) begin
            q0 <= '0;
            q1 <= '0;
            if (sweep_we)
                mem[sweep_addr] <= '0;
        end else begin
            q0 <= mem[a0];
            q1 <= mem[a1];
            // Port 1 first so port 0's later assignment wins on a shared address.
            if (we1 && a1_ok)
                mem[a1] <= d1;
            if (we0 && a0_ok)
                mem[a0] <= d0;
        end
    end

`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            collision <= 1'b0;
        else
            collision <= init_done && (a0 == a1) && (we0 || we1);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn && init_done && we0 && we1 && (a0 == a1))
            $display("generic_dual_port_sram: warning, both ports wrote address %0h", a0);
    end
`endif
`endif

endmodule

// File: tb/tb_generic_dual_port_sram.sv
// Directed self-checking bench for generic_dual_port_sram at abits=4, dbits=4.
module tb_generic_dual_port_sram;

    localparam int AB = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AB-1:0] a0, a1;
    logic [DB-1:0] d0, d1, q0, q1;
    logic          we0, we1, init_done;
`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
    logic          collision;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    generic_dual_port_sram #(.abits(AB), .dbits(DB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .a0        (a0),
        .d0        (d0),
        .we0       (we0),
        .q0        (q0),
        .a1        (a1),
        .d1        (d1),
        .we1       (we1),
        .q1        (q1),
`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
        .collision (collision),
`endif
        .init_done (init_done)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr0(input logic [AB-1:0] a, input logic [DB-1:0] d);
        a0 = a; d0 = d; we0 = 1'b1;
        tick();
        we0 = 1'b0;
    endtask

    task automatic test_reset();
        int done_at;
        rstn = 1'b0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({q0, q1, init_done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got q0=%h q1=%h done=%b, want 0 0 0", q0, q1, init_done);
            end
        end
        rstn = 1'b1;
        // Attempted write during the sweep must be dropped.
        a0 = 4'd1; d0 = 4'hF; we0 = 1'b1;
        a1 = 4'd1; d1 = 4'hE; we1 = 1'b1;
        done_at = -1;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            tick();
            if (init_done) done_at = n;
            else if (q0 !== '0 || q1 !== '0) begin
                errors++;
                $display("FAIL sweep_q_hold: cycle %0d got q0=%h q1=%h, want 0", n, q0, q1);
            end
        end
        we0 = 1'b0; we1 = 1'b0;
        vectors++;
        if (done_at !== 16) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles, want 16", done_at);
        end
        for (int a = 0; a < 16; a++) begin
            a0 = AB'(a); a1 = AB'(15 - a);
            tick();
            vectors++;
            if (q0 !== '0 || q1 !== '0) begin
                errors++;
                $display("FAIL init_zero: addr %0d got q0=%h q1=%h, want 0", a, q0, q1);
            end
        end
    endtask

    task automatic test_basic_rw();
        wr0(4'd5, 4'hA);
        a1 = 4'd5;
        tick();
        vectors++;
        if (q1 !== 4'hA) begin
            errors++;
            $display("FAIL basic_rw: got q1=%h, want a", q1);
        end
    endtask

    task automatic test_read_first();
        wr0(4'd3, 4'h1);
        a1 = 4'd3; d1 = 4'h7; we1 = 1'b1;
        tick();
        we1 = 1'b0;
        vectors++;
        if (q1 !== 4'h1) begin
            errors++;
            $display("FAIL read_first_old: got q1=%h, want 1", q1);
        end
        tick();
        vectors++;
        if (q1 !== 4'h7) begin
            errors++;
            $display("FAIL read_first_new: got q1=%h, want 7", q1);
        end
    endtask

    task automatic test_cross_port();
        // Port 0 writes addr 5 while port 1 reads it: reader sees old 0xA.
        a0 = 4'd5; d0 = 4'h6; we0 = 1'b1; a1 = 4'd5;
        tick();
        we0 = 1'b0;
        vectors++;
        if (q1 !== 4'hA) begin
            errors++;
            $display("FAIL cross_read_old: got q1=%h, want a", q1);
        end
        tick();
        vectors++;
        if (q1 !== 4'h6) begin
            errors++;
            $display("FAIL cross_read_new: got q1=%h, want 6", q1);
        end
    endtask

    task automatic test_dual_write();
        wr0(4'd2, 4'h3);
        a0 = 4'd2; a1 = 4'd2; d0 = 4'h5; d1 = 4'h9; we0 = 1'b1; we1 = 1'b1;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        vectors++;
        if (q0 !== 4'h3 || q1 !== 4'h3) begin
            errors++;
            $display("FAIL dual_write_old: got q0=%h q1=%h, want 3 3", q0, q1);
        end
`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
        vectors++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL collision_set: got %b, want 1", collision);
        end
`endif
        a1 = 4'd7;
        tick();
        vectors++;
        if (q0 !== 4'h5) begin
            errors++;
            $display("FAIL dual_write_winner: got q0=%h, want 5", q0);
        end
`ifdef GENERIC_SRAM_COLLISION_FLAG_EN
        vectors++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear: got %b, want 0", collision);
        end
`endif
    endtask

    task automatic test_boundary();
        wr0(4'd15, 4'hB);
        wr0(4'd0, 4'h4);
        a0 = 4'd15; a1 = 4'd0;
        tick();
        vectors++;
        if (q0 !== 4'hB || q1 !== 4'h4) begin
            errors++;
            $display("FAIL boundary_addr: got q0=%h q1=%h, want b 4", q0, q1);
        end
    endtask

    task automatic test_mid_reset();
        for (int a = 0; a < 16; a++) wr0(AB'(a), 4'hC);
        a1 = 4'd9;
        tick();
        vectors++;
        if (q1 !== 4'hC) begin
            errors++;
            $display("FAIL fill_check: got q1=%h, want c", q1);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        vectors++;
        if (init_done !== 1'b0 || q1 !== '0) begin
            errors++;
            $display("FAIL mid_reset_drop: got done=%b q1=%h, want 0 0", init_done, q1);
        end
        for (int n = 0; n < 16; n++) tick();
        vectors++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_done: got %b after 16 cycles, want 1", init_done);
        end
        for (int a = 0; a < 16; a++) begin
            a0 = AB'(a); a1 = AB'(a);
            tick();
            vectors++;
            if (q0 !== '0 || q1 !== '0) begin
                errors++;
                $display("FAIL mid_reset_zero: addr %0d got q0=%h q1=%h, want 0", a, q0, q1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_read_first();
        test_cross_port();
        test_dual_write();
        test_boundary();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
